// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM command sequencer.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RD_LAT     = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    RSP   = 3'd4
  } ctrl_state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// In-order command FIFO; count is one bit wider than the wrapping pointers.
module cmd_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ram_cmd_t                 push_data,
  input  logic                     pop,
  output ram_cmd_t                 pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  ram_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Requests against a full or empty FIFO are ignored rather than corrupting state.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Sequences queued write/read commands onto the RAM pins strictly in order
// and returns read data over a valid/ready response port.
module ram_cmd_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and its payload stay stable until that edge.

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  ram_cmd_t          push_cmd, head_cmd;
  logic              fifo_full, fifo_empty, fifo_pop, issue;
  logic [FCW-1:0]    fifo_count;

  assign push_cmd  = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    issue       = 1'b0;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: issue = !fifo_empty;
      WR: begin
        issue = !fifo_empty;
        if (fifo_empty) state_d = IDLE;
      end
      RD: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = RWAIT;
      end
      RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_rdata_d = ram_rdata;
          rsp_addr_d  = ram_addr_q;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          issue = !fifo_empty;
          if (fifo_empty) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issuing pops the head and registers the RAM pins for the next state.
    if (issue) begin
      fifo_pop    = 1'b1;
      state_d     = head_cmd.wr ? WR : RD;
      ram_wr_d    = head_cmd.wr;
      ram_addr_d  = head_cmd.addr;
      ram_wdata_d = head_cmd.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Directed bench for ram_cmd_ctrl with a behavioural 8x8 RAM (1-cycle read).
module tb_ram_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       ram_wr;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t         wr_log[$];
  ev_t         rsp_log[$];
  logic [10:0] exp_q[$];
  logic [7:0]  ram_mem [8];

  ram_cmd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // RAM model: synchronous write, read data registered one cycle after address.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Monitor samples mid-low-phase, after the bench has driven its inputs.
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      if (ram_wr) wr_log.push_back('{cyc, ram_addr, ram_wdata});
      if (rsp_valid && rsp_ready) rsp_log.push_back('{cyc, rsp_addr, rsp_rdata});
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [7:0] d,
                          output int acc);
    int n;
    n         = 0;
    acc       = -1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL send_accept ready=%0b exp=1 addr=%0d", cmd_ready, a);
      cmd_valid = 1'b0;
    end else begin
      acc = cyc;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < 100) begin
      step();
      k++;
    end
    total++;
    if (rsp_log.size() < n) begin
      bad++;
      $display("FAIL %s rsp_count=%0d exp=%0d", name, rsp_log.size(), n);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    step();
    step();
    total += 8;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=00", rsp_rdata); end
    if (rsp_addr !== 3'd0) begin bad++; $display("FAIL rst_rsp_addr got=%0d exp=0", rsp_addr); end
    if (ram_wr !== 1'b0) begin bad++; $display("FAIL rst_ram_wr got=%b exp=0", ram_wr); end
    if (ram_addr !== 3'd0) begin bad++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
    if (ram_wdata !== 8'h00) begin bad++; $display("FAIL rst_ram_wdata got=%h exp=00", ram_wdata); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] addrs [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [7:0] vals  [4] = '{8'h0A, 8'h14, 8'h1E, 8'h28};
    int acc0, acc;
    wr_log.delete();
    rsp_log.delete();
    send_cmd(1'b1, addrs[0], vals[0], acc0);
    for (int i = 1; i < 4; i++) send_cmd(1'b1, addrs[i], vals[i], acc);
    repeat (8) step();
    total++;
    if (wr_log.size() != 4) begin
      bad++;
      $display("FAIL b2b_write_count got=%0d exp=4", wr_log.size());
    end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      total += 3;
      if (wr_log[i].addr !== addrs[i]) begin bad++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, wr_log[i].addr, addrs[i]); end
      if (wr_log[i].data !== vals[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, wr_log[i].data, vals[i]); end
      if (wr_log[i].cyc != acc0 + 2 + i) begin bad++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, wr_log[i].cyc, acc0 + 2 + i); end
    end
    for (int i = 0; i < 4; i++) begin
      rsp_log.delete();
      send_cmd(1'b0, addrs[i], 8'h00, acc);
      wait_rsp(1, "readback");
      if (rsp_log.size() > 0) begin
        total += 3;
        if (rsp_log[0].data !== vals[i]) begin bad++; $display("FAIL rb_data[%0d] got=%h exp=%h", i, rsp_log[0].data, vals[i]); end
        if (rsp_log[0].addr !== addrs[i]) begin bad++; $display("FAIL rb_addr[%0d] got=%0d exp=%0d", i, rsp_log[0].addr, addrs[i]); end
        if (rsp_log[0].cyc - acc != 4) begin bad++; $display("FAIL rb_latency[%0d] got=%0d exp=4", i, rsp_log[0].cyc - acc); end
      end
      step();
    end
  endtask

  task automatic test_write_then_read();
    int a0, a1;
    wr_log.delete();
    rsp_log.delete();
    send_cmd(1'b1, 3'd5, 8'h55, a0);
    send_cmd(1'b0, 3'd5, 8'h00, a1);
    wait_rsp(1, "wtr_rsp");
    if (rsp_log.size() > 0) begin
      total += 3;
      if (rsp_log[0].data !== 8'h55) begin bad++; $display("FAIL wtr_data got=%h exp=55", rsp_log[0].data); end
      if (rsp_log[0].addr !== 3'd5) begin bad++; $display("FAIL wtr_addr got=%0d exp=5", rsp_log[0].addr); end
      if (rsp_log[0].cyc - a1 != 4) begin bad++; $display("FAIL wtr_latency got=%0d exp=4", rsp_log[0].cyc - a1); end
    end
    if (wr_log.size() > 0) begin
      total++;
      if (wr_log[0].cyc != a0 + 2) begin bad++; $display("FAIL wtr_write_cycle got=%0d exp=%0d", wr_log[0].cyc, a0 + 2); end
    end
    step();
  endtask

  task automatic test_backpressure();
    int acc;
    logic [10:0] got;
    wr_log.delete();
    rsp_log.delete();
    exp_q.delete();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd1, 8'h00, acc);
    send_cmd(1'b1, 3'd6, 8'h66, acc);
    send_cmd(1'b0, 3'd6, 8'h00, acc);
    send_cmd(1'b1, 3'd7, 8'h77, acc);
    send_cmd(1'b0, 3'd0, 8'h00, acc);
    exp_q.push_back({3'd1, 8'h14});
    exp_q.push_back({3'd6, 8'h66});
    exp_q.push_back({3'd0, 8'h0A});
    // Sixth command is offered while the FIFO is full.
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 3'd2;
    cmd_wdata = 8'h22;
    for (int i = 0; i < 5; i++) begin
      total += 4;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready[%0d] got=%b exp=0", i, cmd_ready); end
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      if (rsp_rdata !== 8'h14) begin bad++; $display("FAIL bp_rsp_rdata[%0d] got=%h exp=14", i, rsp_rdata); end
      if (rsp_addr !== 3'd1) begin bad++; $display("FAIL bp_rsp_addr[%0d] got=%0d exp=1", i, rsp_addr); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b exp=0", cmd_ready); end
    step();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL after_pop_ready got=%b exp=1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    wait_rsp(3, "bp_drain");
    repeat (6) step();
    for (int i = 0; i < 3 && i < rsp_log.size(); i++) begin
      got = {rsp_log[i].addr, rsp_log[i].data};
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL bp_rsp_order[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    total++;
    if (wr_log.size() != 3) begin
      bad++;
      $display("FAIL bp_write_count got=%0d exp=3", wr_log.size());
    end else begin
      total += 3;
      if ({wr_log[0].addr, wr_log[0].data} !== {3'd6, 8'h66}) begin bad++; $display("FAIL bp_wr0 got=%0d/%h exp=6/66", wr_log[0].addr, wr_log[0].data); end
      if ({wr_log[1].addr, wr_log[1].data} !== {3'd7, 8'h77}) begin bad++; $display("FAIL bp_wr1 got=%0d/%h exp=7/77", wr_log[1].addr, wr_log[1].data); end
      if ({wr_log[2].addr, wr_log[2].data} !== {3'd2, 8'h22}) begin bad++; $display("FAIL bp_wr2 got=%0d/%h exp=2/22", wr_log[2].addr, wr_log[2].data); end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    wr_log.delete();
    rsp_log.delete();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd1, 8'h00, acc);
    send_cmd(1'b0, 3'd3, 8'h00, acc);
    send_cmd(1'b1, 3'd3, 8'hEE, acc);
    send_cmd(1'b1, 3'd4, 8'hDD, acc);
    send_cmd(1'b1, 3'd5, 8'hCC, acc);
    rsp_ready = 1'b1;
    step();
    step();
    // Read of address 3 is now in RWAIT with three commands queued.
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid_pre got=%b exp=0", rsp_valid); end
    rst = 1'b1;
    #1;
    total += 4;
    if (ram_wr !== 1'b0) begin bad++; $display("FAIL mid_ram_wr got=%b exp=0", ram_wr); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_cmd_ready got=%b exp=1", cmd_ready); end
    step();
    step();
    rst = 1'b0;
    wr_log.delete();
    rsp_log.delete();
    repeat (10) step();
    total += 2;
    if (wr_log.size() != 0) begin bad++; $display("FAIL mid_stale_writes got=%0d exp=0", wr_log.size()); end
    if (rsp_log.size() != 0) begin bad++; $display("FAIL mid_stale_rsps got=%0d exp=0", rsp_log.size()); end
    send_cmd(1'b1, 3'd6, 8'h61, acc);
    send_cmd(1'b0, 3'd3, 8'h00, acc);
    wait_rsp(1, "mid_new_rsp");
    repeat (3) step();
    if (rsp_log.size() > 0) begin
      total += 2;
      if (rsp_log[0].data !== 8'h1E) begin bad++; $display("FAIL mid_new_rdata got=%h exp=1e", rsp_log[0].data); end
      if (rsp_log[0].addr !== 3'd3) begin bad++; $display("FAIL mid_new_raddr got=%0d exp=3", rsp_log[0].addr); end
    end
    total++;
    if (wr_log.size() != 1) begin
      bad++;
      $display("FAIL mid_new_writes got=%0d exp=1", wr_log.size());
    end else begin
      total++;
      if ({wr_log[0].addr, wr_log[0].data} !== {3'd6, 8'h61}) begin bad++; $display("FAIL mid_new_wr got=%0d/%h exp=6/61", wr_log[0].addr, wr_log[0].data); end
    end
  endtask

  task automatic test_wrap();
    int acc;
    rsp_log.delete();
    send_cmd(1'b1, 3'd7, 8'h7E, acc);
    send_cmd(1'b1, 3'd0, 8'h08, acc);
    send_cmd(1'b0, 3'd7, 8'h00, acc);
    send_cmd(1'b0, 3'd0, 8'h00, acc);
    wait_rsp(2, "wrap_rsp");
    if (rsp_log.size() >= 2) begin
      total += 2;
      if ({rsp_log[0].addr, rsp_log[0].data} !== {3'd7, 8'h7E}) begin bad++; $display("FAIL wrap_rsp0 got=%0d/%h exp=7/7e", rsp_log[0].addr, rsp_log[0].data); end
      if ({rsp_log[1].addr, rsp_log[1].data} !== {3'd0, 8'h08}) begin bad++; $display("FAIL wrap_rsp1 got=%0d/%h exp=0/08", rsp_log[1].addr, rsp_log[1].data); end
    end
    repeat (3) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle_busy got=%b exp=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram_mem[i] = 8'h00;
    ram_rdata = 8'h00;
    test_reset();
    test_back_to_back();
    test_write_then_read();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
